// File: rtl/sram_seq_pkg.sv
// Shared types and helpers for the compute-SRAM sequencer: op encoding,
// sequencer states and binary-to-one-hot row decode.
package sram_seq_pkg;

  typedef enum logic [1:0] {
    OP_AND   = 2'b00,
    OP_NOR   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_STORE = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    EVAL  = 3'd2,
    CAPT  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam int ROWS = 16;

  function automatic logic [ROWS-1:0] row_onehot(input logic [3:0] idx);
    row_onehot = {{(ROWS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter. Bit 0 is the core port, bit 1 the debug
// port; the last-grant pointer starts on debug so core wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_reg;  // 1 = debug was granted last

  always_comb begin
    grant = req;
    if (req == 2'b11)
      grant = last_reg ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (RST)
      last_reg <= 1'b1;
    else if (advance && (grant != 2'b00))
      last_reg <= grant[1];
  end

endmodule

// File: rtl/sram_seq.sv
// Multi-cycle sequencer for the 16-row compute SRAM: arbitrates core/debug
// requests and expands each into precharge -> evaluate/write -> capture.
module sram_seq
  import sram_seq_pkg::*;
#(
  parameter int EVAL_CYC = 1,
  parameter int WR_CYC   = 1
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        core_req,
  input  logic [1:0]  core_op,
  input  logic [15:0] core_src,
  input  logic [15:0] core_dst,
  input  logic [15:0] core_wdata,
  input  logic        dbg_req,
  input  logic [1:0]  dbg_op,
  input  logic [3:0]  dbg_row_a,
  input  logic [3:0]  dbg_row_b,
  input  logic [15:0] dbg_wdata,
  input  logic [15:0] sram_data_out,
  output logic        core_stall,
  output logic        core_done,
  output logic        dbg_done,
  output logic [15:0] rdata,
  output logic        precharge,
  output logic [15:0] RWL,
  output logic [15:0] WWL,
  output logic        SRAM_write_en,
  output logic        control,
  output logic [15:0] sram_wdata
);

  // Counters run from N-1 down to 0, giving exactly N cycles in the phase.
  localparam logic [3:0] EVAL_LOAD = 4'(EVAL_CYC - 1);
  localparam logic [3:0] WR_LOAD   = 4'(WR_CYC - 1);

  state_e      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  op_e         op_reg;
  logic [15:0] src_reg, dst_reg, wdata_reg, rdata_reg;
  logic        port_reg;  // 1 = debug owns the current op

  logic [1:0]  grant;
  logic        accept;
  logic [15:0] dbg_src, dbg_dst;

  rr_arb2 u_arb (
    .clk     (clk),
    .RST     (RST),
    .req     ({dbg_req, core_req}),
    .advance (state_reg == IDLE),
    .grant   (grant)
  );

  assign accept  = (state_reg == IDLE) && (grant != 2'b00);
  assign dbg_src = row_onehot(dbg_row_a);
  assign dbg_dst = (op_e'(dbg_op) == OP_STORE) ? row_onehot(dbg_row_a)
                                               : row_onehot(dbg_row_b);

  always_ff @(posedge clk) begin
    if (RST) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      op_reg    <= OP_AND;
      src_reg   <= 16'd0;
      dst_reg   <= 16'd0;
      wdata_reg <= 16'd0;
      port_reg  <= 1'b0;
      rdata_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        port_reg <= grant[1];
        if (grant[1]) begin
          op_reg    <= op_e'(dbg_op);
          src_reg   <= dbg_src;
          dst_reg   <= dbg_dst;
          wdata_reg <= dbg_wdata;
        end else begin
          op_reg    <= op_e'(core_op);
          src_reg   <= core_src;
          dst_reg   <= core_dst;
          wdata_reg <= core_wdata;
        end
      end
      if (state_reg == CAPT)
        rdata_reg <= sram_data_out;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: if (accept) state_next = PRE;
      PRE: begin
        if (op_reg == OP_STORE) begin
          state_next = WRITE;
          cnt_next   = WR_LOAD;
        end else begin
          state_next = EVAL;
          cnt_next   = EVAL_LOAD;
        end
      end
      EVAL: begin
        if (cnt_reg == 4'd0) state_next = CAPT;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      CAPT: state_next = DONE;
      WRITE: begin
        if (cnt_reg == 4'd0) state_next = DONE;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Word lines and precharge decode purely from state, so they cannot overlap.
  always_comb begin
    precharge     = 1'b0;
    RWL           = 16'd0;
    WWL           = 16'd0;
    SRAM_write_en = 1'b0;
    control       = 1'b0;
    sram_wdata    = 16'd0;
    core_done     = 1'b0;
    dbg_done      = 1'b0;
    case (state_reg)
      PRE: precharge = 1'b1;
      EVAL, CAPT: begin
        RWL     = (op_reg == OP_LOAD) ? src_reg : (src_reg | dst_reg);
        control = (op_reg == OP_NOR);
      end
      WRITE: begin
        WWL           = dst_reg;
        SRAM_write_en = 1'b1;
        sram_wdata    = wdata_reg;
      end
      DONE: begin
        core_done = ~port_reg;
        dbg_done  = port_reg;
      end
      default: ;
    endcase
  end

  assign core_stall = core_req & ~core_done;
  assign rdata      = rdata_reg;

endmodule

// File: tb/tb_sram_seq.sv
// Directed bench for sram_seq: one instance with EVAL_CYC=1/WR_CYC=3 checked
// cycle by cycle, a second with EVAL_CYC=4/WR_CYC=4 sharing the same stimulus.
module tb_sram_seq;

  logic        clk = 1'b0;
  logic        RST;
  logic        core_req;
  logic [1:0]  core_op;
  logic [15:0] core_src, core_dst, core_wdata;
  logic        dbg_req;
  logic [1:0]  dbg_op;
  logic [3:0]  dbg_row_a, dbg_row_b;
  logic [15:0] dbg_wdata;
  logic [15:0] sram_data_out;

  logic        a_core_stall, a_core_done, a_dbg_done, a_precharge, a_wen, a_control;
  logic [15:0] a_rdata, a_RWL, a_WWL, a_sram_wdata;
  logic        b_core_stall, b_core_done, b_dbg_done, b_precharge, b_wen, b_control;
  logic [15:0] b_rdata, b_RWL, b_WWL, b_sram_wdata;

  int n_tests = 0;
  int n_fail  = 0;
  int ovl_cnt = 0;
  int a_wen_cnt = 0;
  int b_wen_cnt = 0;

  always #5 clk = ~clk;

  sram_seq #(.EVAL_CYC(1), .WR_CYC(3)) dut_a (
    .clk(clk), .RST(RST),
    .core_req(core_req), .core_op(core_op), .core_src(core_src),
    .core_dst(core_dst), .core_wdata(core_wdata),
    .dbg_req(dbg_req), .dbg_op(dbg_op), .dbg_row_a(dbg_row_a),
    .dbg_row_b(dbg_row_b), .dbg_wdata(dbg_wdata),
    .sram_data_out(sram_data_out),
    .core_stall(a_core_stall), .core_done(a_core_done), .dbg_done(a_dbg_done),
    .rdata(a_rdata), .precharge(a_precharge), .RWL(a_RWL), .WWL(a_WWL),
    .SRAM_write_en(a_wen), .control(a_control), .sram_wdata(a_sram_wdata)
  );

  sram_seq #(.EVAL_CYC(4), .WR_CYC(4)) dut_b (
    .clk(clk), .RST(RST),
    .core_req(core_req), .core_op(core_op), .core_src(core_src),
    .core_dst(core_dst), .core_wdata(core_wdata),
    .dbg_req(dbg_req), .dbg_op(dbg_op), .dbg_row_a(dbg_row_a),
    .dbg_row_b(dbg_row_b), .dbg_wdata(dbg_wdata),
    .sram_data_out(sram_data_out),
    .core_stall(b_core_stall), .core_done(b_core_done), .dbg_done(b_dbg_done),
    .rdata(b_rdata), .precharge(b_precharge), .RWL(b_RWL), .WWL(b_WWL),
    .SRAM_write_en(b_wen), .control(b_control), .sram_wdata(b_sram_wdata)
  );

  // Continuous overlap and write-cycle monitors for both instances.
  always @(negedge clk) begin
    if (a_precharge && ((a_RWL != 16'd0) || (a_WWL != 16'd0))) ovl_cnt++;
    if ((a_RWL != 16'd0) && (a_WWL != 16'd0)) ovl_cnt++;
    if (b_precharge && ((b_RWL != 16'd0) || (b_WWL != 16'd0))) ovl_cnt++;
    if ((b_RWL != 16'd0) && (b_WWL != 16'd0)) ovl_cnt++;
    if (a_wen) a_wen_cnt++;
    if (b_wen) b_wen_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until dut_a pulses a done; bounded so a stuck DUT still ends.
  task automatic wait_done_a(output logic cd, output logic dd);
    cd = 1'b0;
    dd = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (a_core_done || a_dbg_done) begin
        cd = a_core_done;
        dd = a_dbg_done;
        return;
      end
    end
    chk("done_timeout", 64'd1, 64'd0);
  endtask

  logic cd, dd;
  int   cyc;

  initial begin
    RST = 1'b1; core_req = 0; core_op = 0; core_src = 0; core_dst = 0; core_wdata = 0;
    dbg_req = 0; dbg_op = 0; dbg_row_a = 0; dbg_row_b = 0; dbg_wdata = 0;
    sram_data_out = 0;
    idle(2);
    chk("rst_outputs", {a_precharge, a_wen, a_control, a_core_done, a_dbg_done}, 5'd0);
    chk("rst_lines", {a_RWL, a_WWL, a_sram_wdata, a_rdata}, 64'd0);
    RST = 1'b0;
    idle(2);

    // Core LOAD: IDLE(0) PRE(1) EVAL(2) CAPT(3) DONE(4)
    core_op = 2'b10; core_src = 16'h0008; core_dst = 16'h0000;
    sram_data_out = 16'hA5A5; core_req = 1'b1;
    #1;
    chk("ld_stall_c0", a_core_stall, 1);
    tick();
    chk("ld_pre_c1", {a_precharge, a_RWL}, {1'b1, 16'h0000});
    chk("ld_stall_c1", a_core_stall, 1);
    tick();
    chk("ld_eval_c2", {a_precharge, a_RWL}, {1'b0, 16'h0008});
    tick();
    chk("ld_capt_c3", {a_RWL, a_rdata, 1'(a_core_stall)}, {16'h0008, 16'h0000, 1'b1});
    tick();
    chk("ld_done_c4", {a_core_done, a_core_stall, a_RWL}, {1'b1, 1'b0, 16'h0000});
    chk("ld_rdata", a_rdata, 16'hA5A5);
    core_req = 1'b0;
    tick();
    chk("ld_done_c5", a_core_done, 0);
    cyc = 5;
    while (!b_core_done && cyc < 15) begin
      tick();
      cyc++;
    end
    chk("ld_b_done_cycle", cyc, 7);
    chk("ld_b_rdata", b_rdata, 16'hA5A5);
    idle(12);

    // Core NOR: control only during EVAL/CAPT
    core_op = 2'b01; core_src = 16'h0001; core_dst = 16'h0100;
    sram_data_out = 16'h0F0F; core_req = 1'b1;
    #1;
    chk("nor_ctrl_c0", a_control, 0);
    tick();
    chk("nor_ctrl_c1", a_control, 0);
    tick();
    chk("nor_eval_c2", {a_control, a_RWL}, {1'b1, 16'h0101});
    tick();
    chk("nor_capt_c3", {a_control, a_RWL}, {1'b1, 16'h0101});
    tick();
    chk("nor_done_c4", {a_core_done, a_control}, 2'b10);
    chk("nor_rdata", a_rdata, 16'h0F0F);
    core_req = 1'b0;
    idle(12);

    // Debug STORE row 5, operands changed after grant must be ignored
    dbg_op = 2'b11; dbg_row_a = 4'd5; dbg_row_b = 4'd9; dbg_wdata = 16'h1234;
    dbg_req = 1'b1;
    tick();
    chk("st_pre_c1", {a_precharge, a_WWL}, {1'b1, 16'h0000});
    dbg_wdata = 16'hFFFF; dbg_row_a = 4'd0;
    for (int i = 2; i < 5; i++) begin
      tick();
      chk($sformatf("st_write_c%0d", i), {a_wen, a_WWL, a_sram_wdata}, {1'b1, 16'h0020, 16'h1234});
    end
    tick();
    chk("st_done_c5", {a_dbg_done, a_core_done, a_wen, a_WWL}, {1'b1, 1'b0, 1'b0, 16'h0000});
    chk("st_rdata_kept", a_rdata, 16'h0F0F);
    dbg_req = 1'b0;
    tick();
    chk("st_done_c6", a_dbg_done, 0);
    idle(12);

    // Both ports held for three ops: core, dbg, core
    core_op = 2'b00; core_src = 16'h0002; core_dst = 16'h0004;
    dbg_op = 2'b10; dbg_row_a = 4'd3; sram_data_out = 16'h3C3C;
    core_req = 1'b1; dbg_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_done_a(cd, dd);
      chk($sformatf("rr_grant%0d", i), {cd, dd}, (i == 1) ? 2'b01 : 2'b10);
    end
    chk("rr_rdata", a_rdata, 16'h3C3C);
    core_req = 1'b0; dbg_req = 1'b0;
    idle(15);

    // Reset during EVAL aborts without a done pulse
    core_op = 2'b10; core_src = 16'h0010; sram_data_out = 16'h5A5A; core_req = 1'b1;
    idle(2);
    chk("rst_mid_eval", a_RWL, 16'h0010);
    RST = 1'b1; core_req = 1'b0;
    tick();
    chk("rst_mid_out", {a_precharge, a_core_done, a_RWL, a_rdata}, 34'd0);
    RST = 1'b0;
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (a_core_done || a_dbg_done) cyc++;
    end
    chk("rst_no_done", cyc, 0);

    // Re-issue after reset: RR pointer back on debug, so core wins the tie
    dbg_op = 2'b10; dbg_row_a = 4'd2;
    core_req = 1'b1; dbg_req = 1'b1;
    wait_done_a(cd, dd);
    chk("reissue_core_first", {cd, dd}, 2'b10);
    chk("reissue_rdata", a_rdata, 16'h5A5A);
    core_req = 1'b0;
    wait_done_a(cd, dd);
    chk("reissue_dbg_next", {cd, dd}, 2'b01);
    dbg_req = 1'b0;
    idle(15);

    chk("overlap_count", ovl_cnt, 0);
    chk("a_write_cycles", a_wen_cnt, 3);
    chk("b_write_cycles", b_wen_cnt, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
